// File: rtl/multi_ce_pkg.sv
// Shared limits and the elaboration-time scale helper for the multi-channel
// fractional clock-enable generator.
package multi_ce_pkg;

  localparam int MAX_CH    = 8;
  localparam int MIN_ACC_W = 16;
  localparam int MAX_ACC_W = 48;

  // Phase increment per Hz: floor(2^acc_w / input_freq); 0 flags an unusable setup.
  function automatic longint unsigned calc_scale(input longint unsigned input_freq,
                                                 input int unsigned       acc_w);
    if (input_freq == 0) return 64'd0;
    return (64'd1 << acc_w) / input_freq;
  endfunction

endpackage

// File: rtl/ce_nco_channel.sv
// One NCO clock-enable channel: rate->inc register, phase accumulator, and the
// clear/run/step priority. CE_RATE_LATCH_EN defers rate updates to period boundaries.
module ce_nco_channel #(
  parameter int              ACC_W  = 32,
  parameter int              RATE_W = 12,
  parameter longint unsigned SCALE  = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_sync_clr,
  output logic              o_ce
);

  localparam logic [ACC_W-1:0] SCALE_W = ACC_W'(SCALE);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic             r_ce;

  logic [ACC_W-1:0] w_rate_ext;
  logic [ACC_W-1:0] w_inc_next;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_ce_next;
  logic             w_inc_upd;

  assign w_rate_ext = ACC_W'(i_rate);
  assign w_inc_next = w_rate_ext * SCALE_W;
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_acc_next = r_acc;
    w_ce_next  = 1'b0;
    if (i_sync_clr) begin
      w_acc_next = '0;
    end else if (i_run) begin
      {w_ce_next, w_acc_next} = w_sum;
    end else begin
      w_ce_next = i_step;
    end
  end

`ifdef CE_RATE_LATCH_EN
  // A zero increment never produces a boundary, so it must be allowed to update freely.
  assign w_inc_upd = w_ce_next || !i_run || (r_inc == '0);
`else
  assign w_inc_upd = 1'b1;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_inc <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_acc <= w_acc_next;
      r_ce  <= w_ce_next;
      if (w_inc_upd) r_inc <= w_inc_next;
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/multi_ce_generator.sv
// NUM_CH independent fractional clock-enable generators sharing rst and sync_clr.
// Optional macro CE_RATE_LATCH_EN: rate changes take effect at period boundaries.
module multi_ce_generator
  import multi_ce_pkg::*;
#(
  parameter int INPUT_FREQ = 25_000_000,
  parameter int NUM_CH     = 2,
  parameter int ACC_W      = 32,
  parameter int RATE_W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*RATE_W-1:0] rate,
  input  logic [NUM_CH-1:0]        run,
  input  logic [NUM_CH-1:0]        step,
  input  logic                     sync_clr,
  output logic [NUM_CH-1:0]        ce
);

  localparam longint unsigned SCALE = calc_scale(longint'(INPUT_FREQ), ACC_W);

  if (SCALE == 0) begin : g_err_scale
    $error("multi_ce_generator: SCALE is 0, INPUT_FREQ too large for ACC_W");
  end
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_err_ch
    $error("multi_ce_generator: NUM_CH out of range");
  end
  if (ACC_W < MIN_ACC_W || ACC_W > MAX_ACC_W) begin : g_err_acc
    $error("multi_ce_generator: ACC_W out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_nco_channel #(
      .ACC_W  (ACC_W),
      .RATE_W (RATE_W),
      .SCALE  (SCALE)
    ) u_ch (
      .clk        (clk),
      .i_rst      (rst),
      .i_rate     (rate[g*RATE_W +: RATE_W]),
      .i_run      (run[g]),
      .i_step     (step[g]),
      .i_sync_clr (sync_clr),
      .o_ce       (ce[g])
    );
  end

endmodule

// File: tb/tb_multi_ce_generator.sv
// Scoreboard bench: a cycle-level arithmetic model of the NCO rules predicts ce,
// a monitor compares every output cycle; directed phases add rate/alignment checks.
module tb_multi_ce_generator;

  localparam int INPUT_FREQ = 1000;
  localparam int NUM_CH     = 2;
  localparam int ACC_W      = 16;
  localparam int RATE_W     = 12;
  localparam longint MOD    = 64'd1 << ACC_W;
  localparam longint SCALE  = MOD / INPUT_FREQ;  // 65

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*RATE_W-1:0] rate = '0;
  logic [NUM_CH-1:0]        run = '0;
  logic [NUM_CH-1:0]        step = '0;
  logic                     sync_clr = 1'b0;
  logic [NUM_CH-1:0]        ce;

  multi_ce_generator #(
    .INPUT_FREQ (INPUT_FREQ),
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .RATE_W     (RATE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rate     (rate),
    .run      (run),
    .step     (step),
    .sync_clr (sync_clr),
    .ce       (ce)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: spec rules in plain integer arithmetic.
  longint m_acc [NUM_CH];
  longint m_inc [NUM_CH];
  bit     m_ce  [NUM_CH];
  logic [NUM_CH-1:0] exp_q[$];

  // Observation statistics (written by monitor, cleared by driver between phases).
  int     pulses  [NUM_CH];
  int     b2b     [NUM_CH];
  int     min_sp  [NUM_CH];
  int     max_sp  [NUM_CH];
  longint last_p  [NUM_CH];
  longint mon_cyc = 0;
  bit     align_watch = 0;
  int     align_err = 0;
  logic [NUM_CH-1:0] prev_ce = '0;

  task automatic clear_stats();
    for (int c = 0; c < NUM_CH; c++) begin
      pulses[c] = 0; b2b[c] = 0; min_sp[c] = 1 << 30; max_sp[c] = 0; last_p[c] = -1;
    end
    align_err = 0;
  endtask

  task automatic model_step(input bit r, input int r0, input int r1,
                            input logic [1:0] rn, input logic [1:0] st, input bit sc);
    int     rv [NUM_CH];
    longint sum, acc_n, inc_new;
    bit     ce_n, upd;
    rv[0] = r0; rv[1] = r1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r) begin
        m_acc[c] = 0; m_inc[c] = 0; m_ce[c] = 0;
      end else begin
        inc_new = (longint'(rv[c]) * SCALE) % MOD;
        if (sc) begin
          acc_n = 0; ce_n = 0;
        end else if (rn[c]) begin
          sum = m_acc[c] + m_inc[c];
          ce_n = (sum >= MOD);
          acc_n = sum % MOD;
        end else begin
          ce_n = st[c]; acc_n = m_acc[c];
        end
        upd = 1;
`ifdef CE_RATE_LATCH_EN
        upd = ce_n || !rn[c] || (m_inc[c] == 0);
`endif
        if (upd) m_inc[c] = inc_new;
        m_acc[c] = acc_n;
        m_ce[c]  = ce_n;
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge and queues the predicted ce.
  task automatic drive(input bit r, input int r0, input int r1,
                       input logic [1:0] rn, input logic [1:0] st, input bit sc);
    logic [NUM_CH-1:0] e;
    @(negedge clk);
    rst      = r;
    rate     = {RATE_W'(r1), RATE_W'(r0)};
    run      = rn;
    step     = st;
    sync_clr = sc;
    model_step(r, r0, r1, rn, st, sc);
    for (int c = 0; c < NUM_CH; c++) e[c] = m_ce[c];
    exp_q.push_back(e);
  endtask

  // Monitor: one expected word per clock edge.
  initial begin
    logic [NUM_CH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ce", longint'(ce), longint'(e));
      end
      mon_cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ce[c] === 1'b1) begin
          if (prev_ce[c] === 1'b1) b2b[c]++;
          if (last_p[c] >= 0) begin
            if (int'(mon_cyc - last_p[c]) < min_sp[c]) min_sp[c] = int'(mon_cyc - last_p[c]);
            if (int'(mon_cyc - last_p[c]) > max_sp[c]) max_sp[c] = int'(mon_cyc - last_p[c]);
          end
          last_p[c] = mon_cyc;
          pulses[c]++;
        end
      end
      if (align_watch && ce[0] !== ce[1]) align_err++;
      prev_ce = ce;
    end
  end

  initial begin
    int  gap;
    bit  seen;
    int  r0, r1;
    logic [1:0] rn, st;
    bit  sc, rr;

    for (int c = 0; c < NUM_CH; c++) begin m_acc[c] = 0; m_inc[c] = 0; m_ce[c] = 0; end
    clear_stats();

    // Reset state
    for (int i = 0; i < 3; i++) drive(1, 100, 100, 2'b11, 2'b11, 1'b0);
    @(negedge clk);
    check("reset_ce", longint'(ce), 0);

    // Free run: ch0 at 100 Hz, ch1 at 0 Hz
    clear_stats();
    for (int i = 0; i < 1000; i++) drive(0, 100, 0, 2'b11, 2'b00, 1'b0);
    @(posedge clk); #2;
    check_range("free_pulses0", pulses[0], 98, 100);
    check_range("free_min_sp0", min_sp[0], 10, 11);
    check_range("free_max_sp0", max_sp[0], 10, 11);
    check("free_b2b0", b2b[0], 0);
    check("free_pulses1", pulses[1], 0);

    // Pause + single step, then 3-cycle held step, then resume
    clear_stats();
    drive(0, 100, 0, 2'b00, 2'b00, 1'b0);
    drive(0, 100, 0, 2'b00, 2'b01, 1'b0);
    drive(0, 100, 0, 2'b00, 2'b00, 1'b0);
    drive(0, 100, 0, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 100, 0, 2'b00, 2'b01, 1'b0);
    drive(0, 100, 0, 2'b00, 2'b00, 1'b0);
    drive(0, 100, 0, 2'b00, 2'b00, 1'b0);
    @(posedge clk); #2;
    check("step_pulses", pulses[0], 4);
    check("step_b2b", b2b[0], 2);
    for (int i = 0; i < 40; i++) drive(0, 100, 0, 2'b01, 2'b01, 1'b0);

    // Randomized operation
    r0 = 100; r1 = 37;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r0 = $urandom_range(0, 499);
        r1 = $urandom_range(0, 499);
      end
      rn = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      st = 2'($urandom);
      sc = ($urandom_range(0, 31) == 0);
      rr = ($urandom_range(0, 63) == 0);
      drive(rr, r0, r1, rn, st, sc);
    end

    // Phase alignment via sync_clr
    for (int i = 0; i < 7; i++) drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 100, 100, 2'b01, 2'b00, 1'b0);
    drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
    drive(0, 100, 100, 2'b11, 2'b11, 1'b1);
    clear_stats();
    align_watch = 1;
    for (int i = 0; i < 300; i++) drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
    @(posedge clk); #2;
    align_watch = 0;
    check("align_err", align_err, 0);
    check_range("align_pulses", pulses[0], 26, 30);

    // Reset one cycle after a carry edge, with step high
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
      if (ce[0] === 1'b1) seen = 1;
    end
    check("rst_wait_carry", seen, 1);
    drive(1, 100, 100, 2'b11, 2'b11, 1'b0);
    gap = -1;
    for (int k = 0; k < 30 && gap < 0; k++) begin
      drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
      if (k == 0) check("rst_drop_ce", longint'(ce), 0);
      else if (ce[0] === 1'b1) gap = k;
    end
    // inc loads one edge after release, then ceil(2^ACC_W / inc) accumulations.
    check("rst_first_gap", gap, ((MOD + 100 * SCALE - 1) / (100 * SCALE)) + 1);

    // Rate change 100 -> 200 mid-period
    for (int i = 0; i < 5; i++) drive(0, 100, 100, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) drive(0, 200, 100, 2'b11, 2'b00, 1'b0);
    clear_stats();
    for (int i = 0; i < 100; i++) drive(0, 200, 100, 2'b11, 2'b00, 1'b0);
    @(posedge clk); #2;
    check_range("rate200_min_sp", min_sp[0], 5, 6);
    check_range("rate200_max_sp", max_sp[0], 5, 6);
    check("rate200_b2b", b2b[0], 0);

    drive(0, 0, 0, 2'b00, 2'b00, 1'b0);
    @(posedge clk); #2;
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
